// File: rtl/fir_wl_pkg.sv
// Shared types and constants for the FIR wordlength scheduler.
// Optional macro FIR_WL_SCHED_STALL_CNT_EN is consumed by fir_wl_sched only.
package fir_wl_pkg;
    localparam int N_TAPS   = 15;
    localparam int WL_W     = 8;
    localparam int MAX_FRAC = 16;
    localparam int DATA_W   = 12;
    localparam int ADDR_W   = 4;

    typedef logic [WL_W-1:0]   wl_t;
    typedef wl_t [N_TAPS-1:0]  wl_arr_t;
    typedef enum logic [1:0] {RUN, FLUSH, SWAP} sched_state_e;

    localparam wl_t     MAX_FRAC_WL = wl_t'(MAX_FRAC);
    localparam wl_arr_t WL_ARR_RST  = {N_TAPS{MAX_FRAC_WL}};

    function automatic wl_t clamp_wl(input wl_t d);
        return (d > MAX_FRAC_WL) ? MAX_FRAC_WL : d;
    endfunction
endpackage

// File: rtl/fir_wl_regfile.sv
// Shadow/active wordlength registers: clamped writes, bad-address flag, swap strobe.
// Writes land in shadow next cycle; active only follows shadow on swap_i.
module fir_wl_regfile
    import fir_wl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [WL_W-1:0]          wr_data_i,
    input  logic                     swap_i,
    output logic                     err_o,
    output logic                     swap_done_o,
    output logic [N_TAPS*WL_W-1:0]   active_o
);
    wl_arr_t shadow_q, shadow_d, active_q;
    logic    err_q, swap_done_q;
    logic    bad_addr;

    assign bad_addr = wr_addr_i >= ADDR_W'(N_TAPS);

    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < N_TAPS; i++) begin
            if (wr_en_i && wr_addr_i == ADDR_W'(i)) begin
                shadow_d[i] = clamp_wl(wr_data_i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q    <= WL_ARR_RST;
            active_q    <= WL_ARR_RST;
            err_q       <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            err_q       <= wr_en_i && bad_addr;
            swap_done_q <= swap_i;
            if (swap_i) begin
                active_q <= shadow_q;
            end
        end
    end

    assign err_o       = err_q;
    assign swap_done_o = swap_done_q;
    assign active_o    = active_q;
endmodule

// File: rtl/fir_wl_sched.sv
// Wordlength scheduler: stalls the source and flushes the FIR for N_TAPS cycles, then swaps configs.
// Optional macro FIR_WL_SCHED_STALL_CNT_EN adds a saturating stall_cnt output.
module fir_wl_sched
    import fir_wl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [WL_W-1:0]          cfg_data,
    input  logic                     cfg_commit,
    output logic                     cfg_err,
    input  logic                     src_valid,
    output logic                     src_ready,
    input  logic [DATA_W-1:0]        src_data,
    output logic                     fir_in_valid,
    output logic [DATA_W-1:0]        fir_data,
    output logic [N_TAPS*WL_W-1:0]   frac_wl,
    output logic                     busy,
`ifdef FIR_WL_SCHED_STALL_CNT_EN
    output logic [15:0]              stall_cnt,
`endif
    output logic                     swap_done
);
    localparam int CNT_W = $clog2(N_TAPS);

    sched_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pending_q;
    logic             cfg_we;

    assign cfg_we = cfg_valid && cfg_ready;

    // Commits seen while flushing are merged into one pending commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (pending_q || cfg_commit) begin
                        state_q   <= FLUSH;
                        cnt_q     <= CNT_W'(N_TAPS - 1);
                        pending_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (cfg_commit) pending_q <= 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= SWAP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SWAP: begin
                    if (cfg_commit) pending_q <= 1'b1;
                    state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign src_ready    = (state_q == RUN);
    assign busy         = (state_q != RUN);
    assign cfg_ready    = (state_q != SWAP);
    assign fir_in_valid = src_ready && src_valid;
    assign fir_data     = src_ready ? src_data : '0;

    fir_wl_regfile u_regfile (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (cfg_we),
        .wr_addr_i   (cfg_addr),
        .wr_data_i   (cfg_data),
        .swap_i      (state_q == SWAP),
        .err_o       (cfg_err),
        .swap_done_o (swap_done),
        .active_o    (frac_wl)
    );

`ifdef FIR_WL_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (src_valid && !src_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule
